tuner_controller: RTL
=====================

// Module: tuner_controller
// PURPOSE
//  Sequences channel selection for the FM receive chain: converts channel commands into the DDS phase
//  constant K, mutes audio while the chain settles, then measures a signal-level metric to decide
//  lock/squelch. Seek mode steps through channels until the level reaches the threshold.
//  One instance per radio core; K drives the DDS, mute gates the demodulated audio path.
// PARAMETERS
//  width_dds  32         DDS accumulator width (width of K)
//  channels   205        number of channels; channel index range 0..channels-1
//  K_min      375809638  K of channel 0 (87.5 MHz at f_s = 1 GHz)
//  K_step     429497     K increment per channel (100 kHz at f_s = 1 GHz)
//  settle     4096       cycles of muted settling after every K change (>=1)
//  meas_log2  8          level averaging window = 2**meas_log2 cycles
// PORTS
//  clk              in   1          single clock; all logic on rising edge
//  reset            in   1          synchronous, active-high reset
//  cmd_valid        in   1          command request
//  cmd_ready        out  1          high only in IDLE; command accepted when cmd_valid & cmd_ready
//  cmd_op           in   2          00 SET, 01 UP, 10 DOWN, 11 SEEK (seek upward)
//  cmd_ch           in   8          target channel for SET (ignored for other ops)
//  level            in   16         unsigned signal-level metric, sampled every cycle in MEASURE
//  level_threshold  in   16         unsigned lock threshold, sampled at end of MEASURE
//  K                out  width_dds  DDS phase constant; changes only on leaving CALC/STEP
//  channel          out  8          channel index corresponding to K
//  mute             out  1          1 = audio muted
//  busy             out  1          1 in any state other than IDLE (= ~cmd_ready)
//  locked           out  1          1 = last measurement average >= level_threshold
// BEHAVIOUR
//  Reset: state IDLE, K=K_min, channel=0, mute=1, locked=0, busy=0, cmd_ready=1, counters cleared.
//  Reset mid-operation overrides everything and returns to this state the next cycle.
//  States: IDLE, CALC, STEP, SETTLE, MEASURE.
//  IDLE: mute = ~locked. On accept: locked<=0, mute<=1, cmd_ready<=0. Commands while busy are not
//   accepted (cmd_ready=0), never queued.
//  SET: target = min(cmd_ch, channels-1); -> CALC with acc=K_min, cnt=0.
//   CALC: one acc+=K_step per cycle while cnt<target; when cnt==target: K<=acc, channel<=target,
//   -> SETTLE. Latency from accept to K update = target+1 cycles (target 0 -> 1 cycle).
//  UP/DOWN/seek step -> STEP (1 cycle): UP: channel==channels-1 ? (0, K_min) : (+1, K+K_step);
//   DOWN: channel==0 ? (channels-1, K_min+(channels-1)*K_step, precomputed constant) : (-1, K-K_step);
//   then -> SETTLE.
//  SETTLE: mute=1; exactly `settle` cycles, then -> MEASURE with sum cleared.
//  MEASURE: sum += level for 2**meas_log2 cycles; sum width 16+meas_log2, no overflow.
//   avg = sum >> meas_log2 (truncate). hit = avg >= level_threshold.
//   SET/UP/DOWN: locked<=hit, -> IDLE.
//   SEEK: hit -> locked<=1, -> IDLE. miss -> steps++; steps==channels (full wrap, back on start
//   channel) -> locked<=0, -> IDLE; else -> STEP (UP direction).
//  K arithmetic modulo 2**width_dds; K and channel always change together in one cycle.
//  mute is 1 in every non-IDLE state; first unmute only after a measurement with hit=1.
// TESTING (settle=4, meas_log2=2, channels=205, defaults otherwise)
//  1 Reset: hold reset 2 cycles -> K=375809638, channel=0, mute=1, locked=0, cmd_ready=1.
//  2 SET ch=10, level=1000, threshold=500 -> K=375809638+10*429497 exactly 11 cycles after accept,
//    busy 11+4+4+1 cycles total, then locked=1, mute=0.
//  3 SET ch=250 -> channel=204; then UP -> channel=0, K=K_min; DOWN -> channel=204 again.
//  4 SEEK from ch 0, level=900 only while channel==3 else 0, threshold=500 -> stops at channel 3,
//    locked=1; channels 1,2 visited with mute=1 throughout.
//  5 SEEK with level=0 constantly -> returns to start channel after 205 steps, locked=0, mute=1.
//  6 Reset asserted mid-SETTLE; cmd_valid held during busy -> back to reset values, held command
//    accepted only on first IDLE cycle after reset release.

Source files
------------

// File: rtl/tuner_controller_if.sv
// Command channel of the tuner controller: valid/ready handshake plus opcode and SET target.
interface tuner_controller_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_ch;

   // Issues commands and observes ready.
   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_ch,
      input  cmd_ready
   );

   // Accepts commands and drives ready.
   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_ch,
      output cmd_ready
   );
endinterface

// File: rtl/tuner_controller.sv
// Tuner controller: converts channel commands into the DDS phase constant K, mutes audio while the
// receive chain settles, then averages a signal-level metric to decide lock. SEEK keeps stepping
// upward until the averaged level reaches the threshold or every channel has been tried once.
module tuner_controller #(
   parameter int unsigned             width_dds = 32,
   parameter int unsigned             channels  = 205,
   parameter logic [width_dds-1:0]    K_min     = width_dds'(375809638),
   parameter logic [width_dds-1:0]    K_step    = width_dds'(429497),
   parameter int unsigned             settle    = 4096,
   parameter int unsigned             meas_log2 = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   tuner_controller_if.slave    cmd_bus,
   input  logic [15:0]          i_level,
   input  logic [15:0]          i_level_threshold,
   output logic [width_dds-1:0] o_k,
   output logic [7:0]           o_channel,
   output logic                 o_mute,
   output logic                 o_busy,
   output logic                 o_locked
);

   localparam int unsigned SumW     = 16 + meas_log2;
   localparam int unsigned SettleW  = $clog2(settle + 1);
   localparam int unsigned StepsW   = $clog2(channels + 1);
   localparam int unsigned MeasCntW = meas_log2 + 1;

   localparam logic [7:0] ChLast = 8'(channels - 1);
   // K of the top channel, used when DOWN wraps from channel 0.
   localparam logic [width_dds-1:0] KTop = K_min + K_step * width_dds'(channels - 1);

   localparam logic [1:0] OpSet  = 2'b00;
   localparam logic [1:0] OpUp   = 2'b01;
   localparam logic [1:0] OpDown = 2'b10;
   localparam logic [1:0] OpSeek = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StCalc,
      StStep,
      StSettle,
      StMeasure
   } state_t;

   // Registered state.
   state_t                 r_state;
   logic [width_dds-1:0]   r_k;
   logic [7:0]             r_channel;
   logic                   r_locked;
   logic [1:0]             r_op;
   logic [7:0]             r_target;
   logic [width_dds-1:0]   r_acc;
   logic [7:0]             r_calc_cnt;
   logic [SettleW-1:0]     r_settle_cnt;
   logic [MeasCntW-1:0]    r_meas_cnt;
   logic [SumW-1:0]        r_sum;
   logic [StepsW-1:0]      r_steps;

   // Next-state values.
   state_t                 w_state;
   logic [width_dds-1:0]   w_k;
   logic [7:0]             w_channel;
   logic                   w_locked;
   logic [1:0]             w_op;
   logic [7:0]             w_target;
   logic [width_dds-1:0]   w_acc;
   logic [7:0]             w_calc_cnt;
   logic [SettleW-1:0]     w_settle_cnt;
   logic [MeasCntW-1:0]    w_meas_cnt;
   logic [SumW-1:0]        w_sum;
   logic [StepsW-1:0]      w_steps;

   logic [15:0]            w_avg;
   logic                   w_hit;

   // Truncating average over the 2**meas_log2 window; sum is wide enough that it cannot overflow.
   assign w_avg = r_sum[SumW-1:meas_log2];
   assign w_hit = (w_avg >= i_level_threshold);

   // Next-state and datapath update for the sequencing FSM.
   always_comb begin
      w_state      = r_state;
      w_k          = r_k;
      w_channel    = r_channel;
      w_locked     = r_locked;
      w_op         = r_op;
      w_target     = r_target;
      w_acc        = r_acc;
      w_calc_cnt   = r_calc_cnt;
      w_settle_cnt = r_settle_cnt;
      w_meas_cnt   = r_meas_cnt;
      w_sum        = r_sum;
      w_steps      = r_steps;

      unique case (r_state)
         StIdle: begin
            if (cmd_bus.cmd_valid) begin
               w_locked = 1'b0;
               w_op     = cmd_bus.cmd_op;
               w_steps  = '0;
               if (cmd_bus.cmd_op == OpSet) begin
                  w_target   = (cmd_bus.cmd_ch > ChLast) ? ChLast : cmd_bus.cmd_ch;
                  w_acc      = K_min;
                  w_calc_cnt = 8'd0;
                  w_state    = StCalc;
               end else begin
                  w_state = StStep;
               end
            end
         end

         // Serial multiply: one K_step addition per cycle until the target is reached.
         StCalc: begin
            if (r_calc_cnt == r_target) begin
               w_k          = r_acc;
               w_channel    = r_target;
               w_settle_cnt = '0;
               w_state      = StSettle;
            end else begin
               w_acc      = r_acc + K_step;
               w_calc_cnt = r_calc_cnt + 8'd1;
            end
         end

         // SEEK always steps upward; only an explicit DOWN goes the other way.
         StStep: begin
            if (r_op == OpDown) begin
               if (r_channel == 8'd0) begin
                  w_channel = ChLast;
                  w_k       = KTop;
               end else begin
                  w_channel = r_channel - 8'd1;
                  w_k       = r_k - K_step;
               end
            end else begin
               if (r_channel == ChLast) begin
                  w_channel = 8'd0;
                  w_k       = K_min;
               end else begin
                  w_channel = r_channel + 8'd1;
                  w_k       = r_k + K_step;
               end
            end
            w_settle_cnt = '0;
            w_state      = StSettle;
         end

         StSettle: begin
            if (r_settle_cnt == SettleW'(settle - 1)) begin
               w_sum      = '0;
               w_meas_cnt = '0;
               w_state    = StMeasure;
            end else begin
               w_settle_cnt = r_settle_cnt + SettleW'(1);
            end
         end

         // Accumulate while the counter MSB is clear, then spend one cycle on the decision so the
         // compare sees the registered sum including the final sample.
         StMeasure: begin
            if (!r_meas_cnt[meas_log2]) begin
               w_sum      = r_sum + SumW'(i_level);
               w_meas_cnt = r_meas_cnt + MeasCntW'(1);
            end else if (r_op == OpSeek) begin
               if (w_hit) begin
                  w_locked = 1'b1;
                  w_state  = StIdle;
               end else begin
                  w_steps = r_steps + StepsW'(1);
                  // A full wrap lands back on the starting channel.
                  if (w_steps == StepsW'(channels)) begin
                     w_locked = 1'b0;
                     w_state  = StIdle;
                  end else begin
                     w_state = StStep;
                  end
               end
            end else begin
               w_locked = w_hit;
               w_state  = StIdle;
            end
         end

         default: begin
            w_state = StIdle;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_k          <= K_min;
         r_channel    <= 8'd0;
         r_locked     <= 1'b0;
         r_op         <= OpSet;
         r_target     <= 8'd0;
         r_acc        <= K_min;
         r_calc_cnt   <= 8'd0;
         r_settle_cnt <= '0;
         r_meas_cnt   <= '0;
         r_sum        <= '0;
         r_steps      <= '0;
      end else begin
         r_state      <= w_state;
         r_k          <= w_k;
         r_channel    <= w_channel;
         r_locked     <= w_locked;
         r_op         <= w_op;
         r_target     <= w_target;
         r_acc        <= w_acc;
         r_calc_cnt   <= w_calc_cnt;
         r_settle_cnt <= w_settle_cnt;
         r_meas_cnt   <= w_meas_cnt;
         r_sum        <= w_sum;
         r_steps      <= w_steps;
      end
   end

   // Outputs decode directly from registered state; mute lifts only in IDLE after a lock.
   assign cmd_bus.cmd_ready = (r_state == StIdle);
   assign o_busy            = (r_state != StIdle);
   assign o_mute            = (r_state != StIdle) | ~r_locked;
   assign o_locked          = r_locked;
   assign o_k               = r_k;
   assign o_channel         = r_channel;

endmodule
